// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator host sequencer: opcodes, FSM states
// and width constants.
package accel_pkg;

  localparam int ADDR_W          = 8;
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_MAX_MAT_WH  = 128;
  localparam int ROW_BITS        = $clog2(DEF_WIDTH);
  localparam int SUBMAT_BITS     = $clog2(DEF_MAX_MAT_WH / DEF_WIDTH);

  localparam logic [2:0] OP_WR_INPUT  = 3'd0;
  localparam logic [2:0] OP_WR_WEIGHT = 3'd1;
  localparam logic [2:0] OP_LOAD_FIFO = 3'd2;
  localparam logic [2:0] OP_MATMUL    = 3'd3;
  localparam logic [2:0] OP_RD_OUTPUT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_PUSH      = 3'd5
  } state_t;

  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_WR_INPUT) || (op == OP_WR_WEIGHT);
  endfunction

  function automatic logic is_single_op(input logic [2:0] op);
    return (op == OP_LOAD_FIFO) || (op == OP_MATMUL);
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Loadable down-counter used to bound the wait for accelerator completion.
// expired is high while the count sits at zero.
module seq_timeout_cnt #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_r;

  // count register: clear wins over load, load wins over decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/accel_host_seq.sv
// Host-side command sequencer: splits host commands into per-row accelerator
// start/done transactions, streams write rows in and output rows out.
module accel_host_seq
  import accel_pkg::*;
#(
  parameter int WIDTH_HEIGHT = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_MAT_WH   = 128,
  parameter int TIMEOUT      = 1024,
  localparam int ROW_W = $clog2(WIDTH_HEIGHT),
  localparam int SUB_W = $clog2(MAX_MAT_WH / WIDTH_HEIGHT),
  localparam int WR_W  = WIDTH_HEIGHT * DATA_WIDTH,
  localparam int RD_W  = WIDTH_HEIGHT * 2 * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [ROW_W-1:0]  cmd_dim_1,
  input  logic [ROW_W-1:0]  cmd_dim_2,
  input  logic [ROW_W-1:0]  cmd_dim_3,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [SUB_W-1:0]  cmd_submat_row,
  input  logic [SUB_W-1:0]  cmd_submat_col,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [WR_W-1:0]   wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [RD_W-1:0]   rdata,
  output logic              busy,
  output logic              err_timeout,
  output logic              acc_start,
  output logic [2:0]        acc_opcode,
  output logic [ROW_W-1:0]  acc_dim_1,
  output logic [ROW_W-1:0]  acc_dim_2,
  output logic [ROW_W-1:0]  acc_dim_3,
  output logic [ADDR_W-1:0] acc_addr_1,
  output logic [SUB_W-1:0]  acc_submat_row,
  output logic [SUB_W-1:0]  acc_submat_col,
  output logic [WR_W-1:0]   acc_input_wr_data,
  output logic [WR_W-1:0]   acc_weight_wr_data,
  input  logic              acc_done,
  input  logic              acc_fifo_ready,
  input  logic [RD_W-1:0]   acc_output_rd_data
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            state_r, state_s;
  logic [2:0]        op_r;
  logic [ROW_W-1:0]  dim1_r, dim2_r, dim3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        len_r, row_r;
  logic [SUB_W-1:0]  sub_row_r, sub_col_r;
  logic [WR_W-1:0]   in_wr_r, wt_wr_r;
  logic [RD_W-1:0]   rdata_r;
  logic              rdata_valid_r, err_r;

  logic accept_s, fetch_s, start_s, row_adv_s, capture_s, pop_s;
  logic tmo_en_s, tmo_exp_s, tmo_expired_s, last_s;

  assign last_s = is_single_op(op_r) || (row_r == len_r);

  seq_timeout_cnt #(.CNT_W(TMO_W)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept_s),
    .load     (start_s),
    .load_val (TMO_W'(TIMEOUT - 1)),
    .en       (tmo_en_s),
    .expired  (tmo_expired_s)
  );

  // next-state and per-cycle strobes
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    fetch_s   = 1'b0;
    start_s   = 1'b0;
    row_adv_s = 1'b0;
    capture_s = 1'b0;
    pop_s     = 1'b0;
    tmo_en_s  = 1'b0;
    tmo_exp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          state_s  = is_write_op(cmd_opcode) ? ST_FETCH : ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (wdata_valid) begin
          fetch_s = 1'b1;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        // unknown opcodes pass through ISSUE once without touching the accelerator
        if (op_r > OP_RD_OUTPUT) begin
          state_s = ST_IDLE;
        end else if ((op_r == OP_MATMUL) && !acc_fifo_ready) begin
          state_s = ST_ISSUE;
        end else begin
          start_s = 1'b1;
          state_s = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        tmo_en_s = 1'b1;
        if (acc_done) begin
          if (op_r == OP_RD_OUTPUT) begin
            state_s = ST_CAPTURE;
          end else if (last_s) begin
            state_s = ST_IDLE;
          end else begin
            row_adv_s = 1'b1;
            state_s   = is_write_op(op_r) ? ST_FETCH : ST_ISSUE;
          end
        end else if (tmo_expired_s) begin
          tmo_exp_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_CAPTURE: begin
        capture_s = 1'b1;
        state_s   = ST_PUSH;
      end
      ST_PUSH: begin
        if (rdata_ready) begin
          pop_s = 1'b1;
          if (last_s) begin
            state_s = ST_IDLE;
          end else begin
            row_adv_s = 1'b1;
            state_s   = ST_ISSUE;
          end
        end else begin
          state_s = ST_PUSH;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // latched command fields and row/address tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= 3'd0;
      dim1_r    <= {ROW_W{1'b0}};
      dim2_r    <= {ROW_W{1'b0}};
      dim3_r    <= {ROW_W{1'b0}};
      addr_r    <= 8'd0;
      len_r     <= 8'd0;
      row_r     <= 8'd0;
      sub_row_r <= {SUB_W{1'b0}};
      sub_col_r <= {SUB_W{1'b0}};
    end else if (accept_s) begin
      op_r      <= cmd_opcode;
      dim1_r    <= cmd_dim_1;
      dim2_r    <= cmd_dim_2;
      dim3_r    <= cmd_dim_3;
      addr_r    <= cmd_addr;
      len_r     <= cmd_len;
      row_r     <= 8'd0;
      sub_row_r <= cmd_submat_row;
      sub_col_r <= cmd_submat_col;
    end else if (row_adv_s) begin
      addr_r <= addr_r + 8'd1;
      row_r  <= row_r + 8'd1;
    end else begin
      addr_r <= addr_r;
      row_r  <= row_r;
    end
  end

  // write-row holding registers toward the accelerator memories
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr_r <= {WR_W{1'b0}};
      wt_wr_r <= {WR_W{1'b0}};
    end else if (fetch_s && (op_r == OP_WR_INPUT)) begin
      in_wr_r <= wdata;
    end else if (fetch_s) begin
      wt_wr_r <= wdata;
    end else begin
      in_wr_r <= in_wr_r;
      wt_wr_r <= wt_wr_r;
    end
  end

  // result row register; held until the host takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r       <= {RD_W{1'b0}};
      rdata_valid_r <= 1'b0;
    end else if (capture_s) begin
      rdata_r       <= acc_output_rd_data;
      rdata_valid_r <= 1'b1;
    end else if (pop_s) begin
      rdata_valid_r <= 1'b0;
    end else begin
      rdata_valid_r <= rdata_valid_r;
    end
  end

  // sticky timeout flag, cleared by the next accepted command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if (tmo_exp_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign cmd_ready          = (state_r == ST_IDLE);
  assign busy               = (state_r != ST_IDLE);
  assign wdata_ready        = (state_r == ST_FETCH);
  assign acc_start          = start_s;
  assign rdata              = rdata_r;
  assign rdata_valid        = rdata_valid_r;
  assign err_timeout        = err_r;
  assign acc_opcode         = op_r;
  assign acc_dim_1          = dim1_r;
  assign acc_dim_2          = dim2_r;
  assign acc_dim_3          = dim3_r;
  assign acc_addr_1         = addr_r;
  assign acc_submat_row     = sub_row_r;
  assign acc_submat_col     = sub_col_r;
  assign acc_input_wr_data  = in_wr_r;
  assign acc_weight_wr_data = wt_wr_r;

endmodule

// File: tb/tb_accel_host_seq.sv
// Directed bench for accel_host_seq with a small behavioural accelerator model.
module tb_accel_host_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd_opcode;
  logic [2:0]   cmd_dim_1, cmd_dim_2, cmd_dim_3;
  logic [7:0]   cmd_addr, cmd_len;
  logic [3:0]   cmd_submat_row, cmd_submat_col;
  logic         wdata_valid, wdata_ready;
  logic [63:0]  wdata;
  logic         rdata_valid, rdata_ready;
  logic [127:0] rdata;
  logic         busy, err_timeout, acc_start;
  logic [2:0]   acc_opcode, acc_dim_1, acc_dim_2, acc_dim_3;
  logic [7:0]   acc_addr_1;
  logic [3:0]   acc_submat_row, acc_submat_col;
  logic [63:0]  acc_input_wr_data, acc_weight_wr_data;
  logic         acc_done, acc_fifo_ready;
  logic [127:0] acc_output_rd_data;

  always #5 clk = ~clk;

  accel_host_seq #(.WIDTH_HEIGHT(8), .DATA_WIDTH(8), .MAX_MAT_WH(128), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_dim_1(cmd_dim_1), .cmd_dim_2(cmd_dim_2), .cmd_dim_3(cmd_dim_3),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_submat_row(cmd_submat_row), .cmd_submat_col(cmd_submat_col),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .err_timeout(err_timeout), .acc_start(acc_start),
    .acc_opcode(acc_opcode), .acc_dim_1(acc_dim_1), .acc_dim_2(acc_dim_2),
    .acc_dim_3(acc_dim_3), .acc_addr_1(acc_addr_1),
    .acc_submat_row(acc_submat_row), .acc_submat_col(acc_submat_col),
    .acc_input_wr_data(acc_input_wr_data), .acc_weight_wr_data(acc_weight_wr_data),
    .acc_done(acc_done), .acc_fifo_ready(acc_fifo_ready),
    .acc_output_rd_data(acc_output_rd_data)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accelerator model: done pulses done_delay cycles after each start;
  // output row for address a is {8{A5,a}}.
  int         n_start = 0;
  int         dcnt = 0;
  int         done_delay = 2;
  bit         done_en = 1'b1;
  logic [7:0]  log_addr [32];
  logic [63:0] log_in   [32];
  logic [63:0] log_wt   [32];

  always @(negedge clk) begin
    acc_done = 1'b0;
    if (acc_start) begin
      if (n_start < 32) begin
        log_addr[n_start] = acc_addr_1;
        log_in[n_start]   = acc_input_wr_data;
        log_wt[n_start]   = acc_weight_wr_data;
      end
      n_start++;
      dcnt = done_delay;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0 && done_en) begin
        acc_done = 1'b1;
        acc_output_rd_data = {8{8'hA5, acc_addr_1}};
      end
    end
  end

  function automatic logic [127:0] rd_row(input logic [7:0] a);
    return {8{8'hA5, a}};
  endfunction

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] len);
    bit ok = 1'b0;
    cmd_opcode = op; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (cmd_ready) ok = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("cmd_accept", {127'd0, ok}, 128'd1);
  endtask

  task automatic put_row(input logic [63:0] d);
    bit ok = 1'b0;
    wdata = d; wdata_valid = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (wdata_ready) ok = 1'b1;
      @(negedge clk);
    end
    wdata_valid = 1'b0;
    check("wdata_taken", {127'd0, ok}, 128'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (!busy) ok = 1'b1;
      else @(negedge clk);
    end
    check(tag, {127'd0, ok}, 128'd1);
  endtask

  task automatic wait_rvalid(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (rdata_valid) ok = 1'b1;
      else @(negedge clk);
    end
    check(tag, {127'd0, ok}, 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] rows [4];
  int base;
  int wcnt;
  logic [7:0] ae;

  initial begin
    rows[0] = 64'h0102030405060708; rows[1] = 64'h1112131415161718;
    rows[2] = 64'hA0A1A2A3A4A5A6A7; rows[3] = 64'hF0E0D0C0B0A09080;
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 3'd0;
    cmd_dim_1 = 3'd2; cmd_dim_2 = 3'd3; cmd_dim_3 = 3'd4;
    cmd_addr = 8'd0; cmd_len = 8'd0; cmd_submat_row = 4'd1; cmd_submat_col = 4'd2;
    wdata_valid = 1'b0; wdata = 64'd0; rdata_ready = 1'b0;
    acc_done = 1'b0; acc_fifo_ready = 1'b1; acc_output_rd_data = 128'd0;
    repeat (3) @(negedge clk);
    check("rst_rdata_valid", {127'd0, rdata_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_err", {127'd0, err_timeout}, 128'd0);
    check("rst_start", {127'd0, acc_start}, 128'd0);
    check("rst_addr", {120'd0, acc_addr_1}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", {127'd0, cmd_ready}, 128'd1);

    // four-row input write from 0x10
    base = n_start;
    send_cmd(3'd0, 8'h10, 8'd3);
    for (int i = 0; i < 4; i++) put_row(rows[i]);
    wait_idle("wr_idle");
    check("wr_starts", 128'(n_start - base), 128'd4);
    for (int i = 0; i < 4; i++) begin
      check("wr_addr", {120'd0, log_addr[base+i]}, 128'(8'h10 + i));
      check("wr_data", {64'd0, log_in[base+i]}, {64'd0, rows[i]});
    end
    check("wr_dim1", {125'd0, acc_dim_1}, 128'd2);
    check("wr_subcol", {124'd0, acc_submat_col}, 128'd2);

    // three-row read across the address wrap, stall on the second row
    base = n_start;
    send_cmd(3'd4, 8'hFE, 8'd2);
    for (int r = 0; r < 3; r++) begin
      ae = 8'hFE + 8'(r);
      wait_rvalid("rd_valid");
      check("rd_data", rdata, rd_row(ae));
      if (r == 1) begin
        repeat (5) @(negedge clk);
        check("rd_hold_valid", {127'd0, rdata_valid}, 128'd1);
        check("rd_hold_data", rdata, rd_row(ae));
      end
      rdata_ready = 1'b1;
      @(negedge clk);
      rdata_ready = 1'b0;
    end
    wait_idle("rd_idle");
    check("rd_starts", 128'(n_start - base), 128'd3);
    check("rd_addr0", {120'd0, log_addr[base]}, 128'hFE);
    check("rd_addr1", {120'd0, log_addr[base+1]}, 128'hFF);
    check("rd_addr2", {120'd0, log_addr[base+2]}, 128'h00);

    // matmul held back by fifo_ready
    acc_fifo_ready = 1'b0;
    base = n_start;
    send_cmd(3'd3, 8'h00, 8'd7);
    repeat (10) @(negedge clk);
    check("mm_no_start", 128'(n_start - base), 128'd0);
    check("mm_busy", {127'd0, busy}, 128'd1);
    acc_fifo_ready = 1'b1;
    wait_idle("mm_idle");
    check("mm_one_start", 128'(n_start - base), 128'd1);

    // timeout with no done
    done_en = 1'b0;
    send_cmd(3'd2, 8'h20, 8'd0);
    check("tmo_start", {127'd0, acc_start}, 128'd1);
    wcnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) wcnt++;
      else break;
    end
    check("tmo_wait_cycles", 128'(wcnt), 128'd16);
    check("tmo_err", {127'd0, err_timeout}, 128'd1);
    check("tmo_cmd_ready", {127'd0, cmd_ready}, 128'd1);
    done_en = 1'b1;

    // unknown opcode: dropped, clears the sticky error
    base = n_start;
    send_cmd(3'd6, 8'h30, 8'd0);
    check("op6_err_clr", {127'd0, err_timeout}, 128'd0);
    check("op6_busy", {127'd0, busy}, 128'd1);
    check("op6_no_start", {127'd0, acc_start}, 128'd0);
    @(negedge clk);
    check("op6_idle", {127'd0, busy}, 128'd0);
    check("op6_starts", 128'(n_start - base), 128'd0);

    // reset while a read row is waiting in PUSH
    send_cmd(3'd4, 8'h40, 8'd0);
    wait_rvalid("rst_push_valid");
    rst = 1'b1;
    #1;
    check("rst_push_rvalid", {127'd0, rdata_valid}, 128'd0);
    check("rst_push_addr", {120'd0, acc_addr_1}, 128'd0);
    check("rst_push_op", {125'd0, acc_opcode}, 128'd0);
    check("rst_push_in", {64'd0, acc_input_wr_data}, 128'd0);
    check("rst_push_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    base = n_start;
    send_cmd(3'd1, 8'h05, 8'd0);
    put_row(64'hDEADBEEFCAFEF00D);
    wait_idle("wt_idle");
    check("wt_starts", 128'(n_start - base), 128'd1);
    check("wt_addr", {120'd0, log_addr[base]}, 128'h05);
    check("wt_data", {64'd0, log_wt[base]}, {64'd0, 64'hDEADBEEFCAFEF00D});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
